cdb_arbiter: RTL and testbench

- Shares the single Common Data Bus between NUM_REQ functional-unit result ports (ALU, MUL/DIV, load).
- Each requester gets a one-entry holding slot with a valid/ready handshake.
- A round-robin scheduler picks one full slot per cycle and drives a registered CDB broadcast to the reservation stations, register status and ROB.
- Speculative results are squashed on branch misprediction.

---
 rtl/cdb_arbiter.sv | 162 ++++++++++++++++
 tb/tb_cdb_arbiter.sv | 316 +++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/cdb_arbiter.sv
// cdb_arbiter: shares the Common Data Bus between NUM_REQ functional-unit
// result ports. Each requester owns a one-entry holding slot; a round-robin
// scheduler picks one full slot per cycle and drives a registered broadcast.
// Speculative slots are flushed when a branch resolves as mispredicted.
module cdb_arbiter #(
  parameter int NUM_REQ           = 3,
  parameter int BW_PROCESSOR_DATA = 32,
  parameter int BW_TAG            = 3
) (
  input  logic                                 clk,
  input  logic                                 rst,
  input  logic [NUM_REQ-1:0]                   i_req_valid,
  output logic [NUM_REQ-1:0]                   o_req_ready,
  input  logic [NUM_REQ*BW_TAG-1:0]            i_req_tag_flatten,
  input  logic [NUM_REQ*BW_PROCESSOR_DATA-1:0] i_req_data_flatten,
  input  logic [NUM_REQ-1:0]                   i_req_speculation,
  input  logic                                 i_branch_valid,
  input  logic                                 i_branch_correct_prediction,
  output logic                                 o_cdb_valid,
  output logic [BW_TAG-1:0]                    o_cdb_tag,
  output logic [BW_PROCESSOR_DATA-1:0]         o_cdb_data,
  output logic [NUM_REQ-1:0]                   o_cdb_grant
);

  localparam int          PTR_W = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;
  localparam int unsigned NR    = NUM_REQ;

  // Holding slots
  logic [NUM_REQ-1:0]                         full_q, full_d;
  logic [NUM_REQ-1:0]                         spec_q, spec_d;
  logic [NUM_REQ-1:0][BW_TAG-1:0]             tag_q, tag_d;
  logic [NUM_REQ-1:0][BW_PROCESSOR_DATA-1:0]  data_q, data_d;

  // Scheduler and broadcast register
  logic [PTR_W-1:0]                           rr_ptr_q, rr_ptr_d;
  logic                                       cdb_valid_q, cdb_valid_d;
  logic [BW_TAG-1:0]                          cdb_tag_q, cdb_tag_d;
  logic [BW_PROCESSOR_DATA-1:0]               cdb_data_q, cdb_data_d;
  logic [NUM_REQ-1:0]                         cdb_grant_q, cdb_grant_d;

  // Unpacked views of the flattened request buses
  logic [NUM_REQ-1:0][BW_TAG-1:0]             req_tag;
  logic [NUM_REQ-1:0][BW_PROCESSOR_DATA-1:0]  req_data;

  logic [NUM_REQ-1:0] sel;
  logic [PTR_W-1:0]   sel_idx;
  logic               sel_any;
  logic               sel_fire;
  logic [NUM_REQ-1:0] accept;
  logic               mispredict;
  logic               predict_ok;

  assign req_tag    = i_req_tag_flatten;
  assign req_data   = i_req_data_flatten;
  assign mispredict = i_branch_valid & ~i_branch_correct_prediction;
  assign predict_ok = i_branch_valid &  i_branch_correct_prediction;

  // A slot being granted this cycle can be refilled in the same cycle.
  assign o_req_ready = ~full_q | sel;
  assign accept      = i_req_valid & o_req_ready;

  // Round-robin pick: the full slot with the smallest circular distance
  // from rr_ptr wins; distance-minimum avoids a variable-indexed wrap search.
  always_comb begin
    int unsigned off;
    int unsigned best_off;
    off      = 0;
    best_off = NR;
    sel_idx  = '0;
    sel      = '0;
    for (int unsigned j = 0; j < NR; j++) begin
      if (j >= 32'(rr_ptr_q)) off = j - 32'(rr_ptr_q);
      else                    off = j + NR - 32'(rr_ptr_q);
      if (full_q[j] && (off < best_off)) begin
        best_off = off;
        sel_idx  = PTR_W'(j);
      end
    end
    sel_any = (best_off < NR);
    for (int unsigned j = 0; j < NR; j++) begin
      sel[j] = sel_any && (PTR_W'(j) == sel_idx);
    end
  end

  // A speculative pick killed by a mispredict is neither broadcast nor
  // allowed to move the round-robin pointer.
  assign sel_fire = sel_any & ~(mispredict & |(sel & spec_q));

  // Slot update: drain on grant, flush on mispredict, then refill on accept.
  always_comb begin
    full_d = full_q;
    spec_d = spec_q;
    tag_d  = tag_q;
    data_d = data_q;
    for (int unsigned k = 0; k < NR; k++) begin
      if (sel[k])                    full_d[k] = 1'b0;
      if (mispredict && spec_q[k])   full_d[k] = 1'b0;
      if (predict_ok)                spec_d[k] = 1'b0;
      if (accept[k]) begin
        full_d[k] = ~(mispredict & i_req_speculation[k]);
        spec_d[k] = i_req_speculation[k] & ~predict_ok;
        tag_d[k]  = req_tag[k];
        data_d[k] = req_data[k];
      end
    end
  end

  // Broadcast register contents and round-robin pointer advance.
  always_comb begin
    cdb_valid_d = sel_fire;
    cdb_grant_d = sel_fire ? sel : '0;
    cdb_tag_d   = '0;
    cdb_data_d  = '0;
    rr_ptr_d    = rr_ptr_q;
    for (int unsigned k = 0; k < NR; k++) begin
      if (sel_fire && sel[k]) begin
        cdb_tag_d  = tag_q[k];
        cdb_data_d = data_q[k];
      end
    end
    if (sel_fire) begin
      rr_ptr_d = (sel_idx == PTR_W'(NUM_REQ - 1)) ? '0 : sel_idx + PTR_W'(1);
    end
  end

  // State registers with synchronous reset.
  always_ff @(posedge clk) begin
    if (rst) begin
      full_q      <= '0;
      spec_q      <= '0;
      tag_q       <= '0;
      data_q      <= '0;
      rr_ptr_q    <= '0;
      cdb_valid_q <= 1'b0;
      cdb_tag_q   <= '0;
      cdb_data_q  <= '0;
      cdb_grant_q <= '0;
    end else begin
      full_q      <= full_d;
      spec_q      <= spec_d;
      tag_q       <= tag_d;
      data_q      <= data_d;
      rr_ptr_q    <= rr_ptr_d;
      cdb_valid_q <= cdb_valid_d;
      cdb_tag_q   <= cdb_tag_d;
      cdb_data_q  <= cdb_data_d;
      cdb_grant_q <= cdb_grant_d;
    end
  end

  assign o_cdb_valid = cdb_valid_q;
  assign o_cdb_tag   = cdb_tag_q;
  assign o_cdb_data  = cdb_data_q;
  assign o_cdb_grant = cdb_grant_q;

  // Tag 0 is the reserved "ready" tag and must never enter a slot.
  for (genvar k = 0; k < NUM_REQ; k++) begin : g_tag_chk
    a_tag_nonzero: assert property (@(posedge clk) disable iff (rst)
      accept[k] |-> (req_tag[k] != '0));
  end

endmodule

// File: tb/tb_cdb_arbiter.sv
// Testbench for cdb_arbiter: cycle-exact vector table plus scoreboard-checked
// directed sequences (single result, back-to-back, reset mid-operation).
module tb_cdb_arbiter;

  localparam int NR = 3;
  localparam int DW = 32;
  localparam int TW = 3;

  logic             clk = 1'b0;
  logic             rst;
  logic [NR-1:0]    req_valid, req_ready, req_spec, cdb_grant;
  logic [NR*TW-1:0] req_tag;
  logic [NR*DW-1:0] req_data;
  logic             br_valid, br_correct, cdb_valid;
  logic [TW-1:0]    cdb_tag;
  logic [DW-1:0]    cdb_data;

  always #5 clk = ~clk;

  cdb_arbiter #(.NUM_REQ(NR), .BW_PROCESSOR_DATA(DW), .BW_TAG(TW)) dut (
    .clk                         (clk),
    .rst                         (rst),
    .i_req_valid                 (req_valid),
    .o_req_ready                 (req_ready),
    .i_req_tag_flatten           (req_tag),
    .i_req_data_flatten          (req_data),
    .i_req_speculation           (req_spec),
    .i_branch_valid              (br_valid),
    .i_branch_correct_prediction (br_correct),
    .o_cdb_valid                 (cdb_valid),
    .o_cdb_tag                   (cdb_tag),
    .o_cdb_data                  (cdb_data),
    .o_cdb_grant                 (cdb_grant)
  );

  int n_checks = 0;
  int n_fail   = 0;
  int cyc      = 0;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  function automatic logic [DW-1:0] mk_data(input int k, input logic [TW-1:0] t);
    return 32'hA000_0000 | (32'(t) << 4) | 32'(k);
  endfunction

  function automatic int oh2idx(input logic [NR-1:0] g);
    int r = 0;
    for (int k = 0; k < NR; k++) if (g[k]) r = k;
    return r;
  endfunction

  // ---------------- scoreboard ----------------
  typedef struct packed {
    logic [NR-1:0] grant;
    logic [TW-1:0] tag;
    logic [DW-1:0] data;
  } bc_t;

  bc_t sb_q[$];
  bit  sb_en    = 1'b0;
  int  bc_count = 0;
  int  bc_first = 0;
  int  bc_last  = 0;

  task automatic sb_push(input logic [NR-1:0] g, input logic [TW-1:0] t, input logic [DW-1:0] d);
    bc_t e;
    e.grant = g;
    e.tag   = t;
    e.data  = d;
    sb_q.push_back(e);
  endtask

  always @(negedge clk) begin : monitor
    bc_t e;
    if (sb_en && cdb_valid) begin
      if (sb_q.size() == 0) begin
        n_checks++;
        n_fail++;
        $display("FAIL sb_unexpected: got broadcast grant=%b tag=%0d data=0x%0h, expected none",
                 cdb_grant, cdb_tag, cdb_data);
      end else begin
        e = sb_q.pop_front();
        chk("sb_grant", cdb_grant, e.grant);
        chk("sb_tag",   cdb_tag,   e.tag);
        chk("sb_data",  cdb_data,  e.data);
      end
      bc_count++;
      if (bc_count == 1) bc_first = cyc;
      bc_last = cyc;
    end
  end

  task automatic drain(input string name);
    int n = 0;
    while (sb_q.size() != 0 && n < 20) begin
      @(negedge clk);
      n++;
    end
    @(negedge clk);
    chk(name, sb_q.size(), 0);
    @(posedge clk); #1;
  endtask

  // ---------------- stimulus helpers ----------------
  task automatic idle_inputs();
    req_valid  = '0;
    req_spec   = '0;
    req_tag    = '0;
    req_data   = '0;
    br_valid   = 1'b0;
    br_correct = 1'b0;
  endtask

  task automatic set_req(input int k, input logic [TW-1:0] t, input logic [DW-1:0] d, input logic s);
    req_valid[k]         = 1'b1;
    req_spec[k]          = s;
    req_tag[k*TW +: TW]  = t;
    req_data[k*DW +: DW] = d;
  endtask

  task automatic next();
    @(posedge clk); #1;
  endtask

  // ---------------- vector table ----------------
  typedef struct packed {
    logic [NR-1:0]         valid;
    logic [NR-1:0]         spec;
    logic [NR-1:0][TW-1:0] tags;
    logic                  br_v;
    logic                  br_c;
    logic [NR-1:0]         exp_ready;
    logic [NR-1:0]         exp_grant;
    logic [TW-1:0]         exp_tag;
  } vec_t;

  vec_t vecs[$];

  function automatic vec_t mkv(input logic [NR-1:0] v, input logic [NR-1:0] s,
                               input logic [TW-1:0] t0, input logic [TW-1:0] t1,
                               input logic [TW-1:0] t2, input logic bv, input logic bc,
                               input logic [NR-1:0] er, input logic [NR-1:0] eg,
                               input logic [TW-1:0] et);
    vec_t r;
    r.valid     = v;
    r.spec      = s;
    r.tags[0]   = t0;
    r.tags[1]   = t1;
    r.tags[2]   = t2;
    r.br_v      = bv;
    r.br_c      = bc;
    r.exp_ready = er;
    r.exp_grant = eg;
    r.exp_tag   = et;
    return r;
  endfunction

  initial begin : watchdog
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "time limit");
  end

  initial begin : main
    logic [DW-1:0] exp_data;

    // Row inputs apply for that cycle; expectations are the outputs seen in
    // that same cycle (broadcast columns reflect the previous cycle's pick).
    //                valid   spec    t0 t1 t2  bv bc  ready   grant   tag
    // contention: all three present every cycle, then stop
    vecs.push_back(mkv(3'b111, 3'b000, 1, 2, 3, 0, 0, 3'b111, 3'b000, 0));
    vecs.push_back(mkv(3'b111, 3'b000, 4, 5, 6, 0, 0, 3'b001, 3'b000, 0));
    vecs.push_back(mkv(3'b111, 3'b000, 7, 5, 6, 0, 0, 3'b010, 3'b001, 1));
    vecs.push_back(mkv(3'b111, 3'b000, 7, 1, 6, 0, 0, 3'b100, 3'b010, 2));
    vecs.push_back(mkv(3'b000, 3'b000, 0, 0, 0, 0, 0, 3'b001, 3'b100, 3));
    vecs.push_back(mkv(3'b000, 3'b000, 0, 0, 0, 0, 0, 3'b011, 3'b001, 4));
    vecs.push_back(mkv(3'b000, 3'b000, 0, 0, 0, 0, 0, 3'b111, 3'b010, 5));
    vecs.push_back(mkv(3'b000, 3'b000, 0, 0, 0, 0, 0, 3'b111, 3'b100, 6));
    vecs.push_back(mkv(3'b000, 3'b000, 0, 0, 0, 0, 0, 3'b111, 3'b000, 0));
    // mispredict squash with rr_ptr=0: speculative tag 4 dies, tag 5 survives
    vecs.push_back(mkv(3'b101, 3'b001, 4, 0, 5, 0, 0, 3'b111, 3'b000, 0));
    vecs.push_back(mkv(3'b000, 3'b000, 0, 0, 0, 1, 0, 3'b011, 3'b000, 0));
    vecs.push_back(mkv(3'b000, 3'b000, 0, 0, 0, 0, 0, 3'b111, 3'b000, 0));
    vecs.push_back(mkv(3'b000, 3'b000, 0, 0, 0, 0, 0, 3'b111, 3'b100, 5));
    vecs.push_back(mkv(3'b000, 3'b000, 0, 0, 0, 0, 0, 3'b111, 3'b000, 0));
    // correct prediction on arriving data, then mispredict drops arriving spec tag 7
    vecs.push_back(mkv(3'b010, 3'b010, 0, 6, 0, 1, 1, 3'b111, 3'b000, 0));
    vecs.push_back(mkv(3'b101, 3'b001, 7, 0, 3, 1, 0, 3'b111, 3'b000, 0));
    vecs.push_back(mkv(3'b000, 3'b000, 0, 0, 0, 0, 0, 3'b111, 3'b010, 6));
    vecs.push_back(mkv(3'b000, 3'b000, 0, 0, 0, 0, 0, 3'b111, 3'b100, 3));
    vecs.push_back(mkv(3'b000, 3'b000, 0, 0, 0, 0, 0, 3'b111, 3'b000, 0));
    // held speculative slot2 cleared by correct branch survives a later mispredict
    vecs.push_back(mkv(3'b111, 3'b100, 1, 2, 7, 0, 0, 3'b111, 3'b000, 0));
    vecs.push_back(mkv(3'b000, 3'b000, 0, 0, 0, 1, 1, 3'b001, 3'b000, 0));
    vecs.push_back(mkv(3'b000, 3'b000, 0, 0, 0, 1, 0, 3'b011, 3'b001, 1));
    vecs.push_back(mkv(3'b000, 3'b000, 0, 0, 0, 0, 0, 3'b111, 3'b010, 2));
    vecs.push_back(mkv(3'b000, 3'b000, 0, 0, 0, 0, 0, 3'b111, 3'b100, 7));
    vecs.push_back(mkv(3'b000, 3'b000, 0, 0, 0, 0, 0, 3'b111, 3'b000, 0));

    // ---- reset, then single result from requester 1 ----
    idle_inputs();
    rst = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    rst = 1'b0;
    set_req(1, 3'd3, 32'h0000_00AA, 1'b0);
    sb_push(3'b010, 3'd3, 32'h0000_00AA);
    sb_en = 1'b1;
    @(negedge clk);
    chk("reset_ready", req_ready, 3'b111);
    chk("reset_cdb_valid", cdb_valid, 1'b0);
    chk("reset_cdb_tag", cdb_tag, '0);
    chk("reset_cdb_data", cdb_data, '0);
    chk("reset_cdb_grant", cdb_grant, '0);
    next();
    idle_inputs();
    @(negedge clk);
    chk("single_valid_c1", cdb_valid, 1'b0);
    chk("single_ready_c1", req_ready, 3'b111);
    next();
    @(negedge clk);
    chk("single_valid_c2", cdb_valid, 1'b1);
    chk("single_ready_c2", req_ready, 3'b111);
    next();
    @(negedge clk);
    chk("single_valid_c3", cdb_valid, 1'b0);
    chk("single_idle_grant", cdb_grant, '0);
    chk("single_idle_tag", cdb_tag, '0);
    chk("single_idle_data", cdb_data, '0);
    next();
    drain("single_drain");

    // ---- back-to-back results from requester 0 ----
    bc_count = 0;
    for (int i = 1; i <= 4; i++) begin
      set_req(0, 3'd1, 32'(i), 1'b0);
      sb_push(3'b001, 3'd1, 32'(i));
      @(negedge clk);
      chk("b2b_ready0", req_ready[0], 1'b1);
      next();
    end
    idle_inputs();
    drain("b2b_drain");
    chk("b2b_count", bc_count, 4);
    chk("b2b_contiguous", bc_last - bc_first, 3);

    // ---- reset mid-operation (rr_ptr is 1 here) ----
    sb_en = 1'b0;
    for (int k = 0; k < NR; k++) set_req(k, 3'(k + 1), mk_data(k, 3'(k + 1)), 1'b0);
    @(negedge clk);
    chk("rst_fill_ready", req_ready, 3'b111);
    next();
    idle_inputs();
    rst = 1'b1;
    @(negedge clk);
    chk("rst_pre_ready", req_ready, 3'b010);
    next();
    rst = 1'b0;
    for (int k = 0; k < NR; k++) begin
      set_req(k, 3'(k + 5), mk_data(k, 3'(k + 5)), 1'b0);
      sb_push(3'(1 << k), 3'(k + 5), mk_data(k, 3'(k + 5)));
    end
    sb_en = 1'b1;
    @(negedge clk);
    chk("rst_post_valid", cdb_valid, 1'b0);
    chk("rst_post_grant", cdb_grant, '0);
    chk("rst_post_ready", req_ready, 3'b111);
    next();
    idle_inputs();
    @(negedge clk);
    chk("rst_refill_ready", req_ready, 3'b001);
    next();
    @(negedge clk);
    chk("rst_first_grant", cdb_grant, 3'b001);
    next();
    drain("rst_drain");

    // ---- table-driven cycle-exact vectors from a fresh reset ----
    sb_en = 1'b0;
    rst = 1'b1;
    next();
    rst = 1'b0;
    for (int i = 0; i < vecs.size(); i++) begin
      req_valid  = vecs[i].valid;
      req_spec   = vecs[i].spec;
      br_valid   = vecs[i].br_v;
      br_correct = vecs[i].br_c;
      for (int k = 0; k < NR; k++) begin
        req_tag[k*TW +: TW]  = vecs[i].tags[k];
        req_data[k*DW +: DW] = mk_data(k, vecs[i].tags[k]);
      end
      exp_data = (vecs[i].exp_grant != '0) ?
                 mk_data(oh2idx(vecs[i].exp_grant), vecs[i].exp_tag) : '0;
      @(negedge clk);
      chk($sformatf("vec%0d_ready", i), req_ready, vecs[i].exp_ready);
      chk($sformatf("vec%0d_valid", i), cdb_valid, |vecs[i].exp_grant);
      chk($sformatf("vec%0d_grant", i), cdb_grant, vecs[i].exp_grant);
      chk($sformatf("vec%0d_tag", i), cdb_tag, vecs[i].exp_tag);
      chk($sformatf("vec%0d_data", i), cdb_data, exp_data);
      next();
    end
    idle_inputs();

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
